// File: rtl/data_sram_like_responder_pkg.sv
// Shared CPU-wide definitions for the data-memory port: access size
// encodings, bus widths and the response-queue entry layout.
package data_sram_like_responder_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    // Timestamp width: 3 bits covers the whole legal latency range 1..7.
    localparam int TS_W = 3;

    // Physical slot count of the response queue; DEPTH parameters up to this
    // value use a prefix of the slots.
    localparam int QMAX = 4;

    typedef struct packed {
        logic              is_load;
        logic [DATA_W-1:0] data;
        logic [TS_W-1:0]   due;
    } resp_entry_t;

    // Merge a store into an existing word, one byte lane per strobe bit.
    function automatic logic [DATA_W-1:0] merge_strobe(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < STRB_W; i++) begin
            if (strb[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_sram_like_responder_if.sv
// sram-like data port between the CPU data side (master) and a memory
// responder (slave).
//
// Handshake: a request transfers on a rising clk edge where req & addr_ok
// are both 1. The master keeps req/wr/size/wstrb/addr/wdata stable while
// req = 1 and addr_ok = 0. addr_ok never depends on req. Each accepted
// request gets exactly one data_ok pulse, in acceptance order, with rdata
// valid in that same cycle; data_ok cannot be stalled by the master.
interface data_sram_like_responder_if;
    import data_sram_like_responder_pkg::*;

    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [STRB_W-1:0] wstrb;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/data_sram_like_responder_resp_queue.sv
// Circular FIFO of pending responses {is_load, data, due}. Push and pop may
// happen on the same edge; the caller never pushes when full nor pops when
// empty.
module resp_queue
    import data_sram_like_responder_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        push,
    input  resp_entry_t push_entry,
    input  logic        pop,
    output resp_entry_t head_entry,
    output logic [2:0]  count,
    output logic        full,
    output logic        empty
);

    resp_entry_t slots [QMAX];
    logic [1:0]  head_ptr;
    logic [1:0]  tail_ptr;

    // Advance a pointer, wrapping at DEPTH rather than at the slot count.
    function automatic logic [1:0] bump(input logic [1:0] p);
        return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // Pointer and occupancy bookkeeping; reset empties the queue.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_ptr <= 2'd0;
            tail_ptr <= 2'd0;
            count    <= 3'd0;
        end else begin
            if (push) tail_ptr <= bump(tail_ptr);
            if (pop)  head_ptr <= bump(head_ptr);
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset: only slots between head and tail are read.
    always_ff @(posedge clk) begin
        if (push) slots[tail_ptr] <= push_entry;
    end

    assign head_entry = slots[head_ptr];
    assign full       = (count == 3'(DEPTH));
    assign empty      = (count == 3'd0);

endmodule

// File: rtl/data_sram_like_responder.sv
// Data-memory responder: word-addressed RAM behind an sram-like slave port,
// fixed response latency, up to QDEPTH requests in flight, in-order replies.
module data_sram_like_responder
    import data_sram_like_responder_pkg::*;
#(
    parameter int AW     = 12,
    parameter int LAT    = 2,
    parameter int QDEPTH = 2
) (
    input logic                       clk,
    input logic                       resetn,
    data_sram_like_responder_if.slave bus
);

    logic [DATA_W-1:0] mem [2**AW];

    logic [TS_W-1:0]   ts;
    logic [AW-1:0]     widx;
    logic [DATA_W-1:0] rd_word;
    logic              accept;
    logic              retire;
    logic              data_ok_q;
    logic [DATA_W-1:0] rdata_q;

    resp_entry_t       push_e;
    resp_entry_t       head_e;
    logic [2:0]        q_count;
    logic              q_full;
    logic              q_empty;

    // Bits that carry no meaning here: size is advisory, the byte offset and
    // the address bits above the RAM index are ignored (addresses alias).
    logic unused_bits;
    assign unused_bits = ^{bus.size, bus.addr[31:AW+2], bus.addr[1:0], q_full};

    assign widx    = bus.addr[AW+1:2];
    assign rd_word = mem[widx];

    // Acceptance is blocked during reset so a held request cannot sneak in.
    assign bus.addr_ok = (q_count < 3'(QDEPTH));
    assign accept      = resetn && bus.req && bus.addr_ok;

    // Fixed latency keeps the head as the next entry due, so only the head
    // is compared. Equality on the 3-bit timestamp is safe because no entry
    // waits longer than 7 cycles.
    assign retire = resetn && !q_empty && (head_e.due == ts);

    // A load captures the RAM word as it stands before this edge's writes.
    assign push_e.is_load = !bus.wr;
    assign push_e.data    = bus.wr ? '0 : rd_word;
    assign push_e.due     = ts + TS_W'(LAT);

    resp_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk        (clk),
        .resetn     (resetn),
        .push       (accept),
        .push_entry (push_e),
        .pop        (retire),
        .head_entry (head_e),
        .count      (q_count),
        .full       (q_full),
        .empty      (q_empty)
    );

    // Free-running timestamp used to stamp due times.
    always_ff @(posedge clk) begin
        if (!resetn) ts <= '0;
        else         ts <= ts + 1'b1;
    end

    // Store write-through with per-lane strobes; contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && bus.wr) begin
            mem[widx] <= merge_strobe(rd_word, bus.wdata, bus.wstrb);
        end
    end

    // Response registers: one-cycle data_ok, rdata held between responses.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            data_ok_q <= retire;
            if (retire) rdata_q <= head_e.is_load ? head_e.data : '0;
        end
    end

    assign bus.data_ok = data_ok_q;
    assign bus.rdata   = rdata_q;

endmodule

// File: tb/tb_data_sram_like_responder.sv
// Bench for data_sram_like_responder: randomized and directed requests,
// a reference memory model and a response scoreboard checked by a monitor.
module tb_data_sram_like_responder;
    import data_sram_like_responder_pkg::*;

    localparam int AW     = 8;
    localparam int LAT    = 2;
    localparam int QDEPTH = 2;
    localparam int WORDS  = 2**AW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    data_sram_like_responder_if bus ();

    data_sram_like_responder #(.AW(AW), .LAT(LAT), .QDEPTH(QDEPTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // ---------------- reference model / scoreboard ----------------
    logic [31:0] model_mem [WORDS];
    logic [31:0] exp_q[$];      // expected rdata per response, in order
    int          exp_due_q[$];  // edge count at which data_ok must appear
    logic [31:0] last_rdata = '0;
    logic        mon_en = 1'b0;
    logic        exp_ok;
    int          total = 0;
    int          bad = 0;

    task automatic check1(input string name, input logic act, input logic expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b at cycle %0d", name, act, expv, cyc);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, expv, cyc);
        end
    endtask

    // Record an accepted request: memory effect plus the response it owes.
    task automatic model_accept(input logic w, input logic [3:0] strb,
                                input logic [31:0] a, input logic [31:0] d);
        logic [AW-1:0] idx;
        idx = a[AW+1:2];
        if (w) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
            end
            exp_q.push_back(32'h0);
        end else begin
            exp_q.push_back(model_mem[idx]);
        end
        exp_due_q.push_back(cyc + LAT);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            exp_ok = (exp_due_q.size() > 0) && (exp_due_q[0] == cyc);
            check1("data_ok", bus.data_ok, exp_ok);
            if (exp_ok) begin
                if (bus.data_ok) check32("rdata", bus.rdata, exp_q[0]);
                void'(exp_q.pop_front());
                void'(exp_due_q.pop_front());
            end
            if (bus.data_ok) last_rdata = bus.rdata;
            else             check32("rdata_hold", bus.rdata, last_rdata);
            check1("addr_ok", bus.addr_ok, exp_due_q.size() < QDEPTH);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic w, input logic [3:0] strb,
                         input logic [31:0] a, input logic [31:0] d);
        int waited;
        waited = 0;
        @(negedge clk);
        bus.req   = 1'b1;
        bus.wr    = w;
        bus.size  = SZ_WORD;
        bus.wstrb = strb;
        bus.addr  = a;
        bus.wdata = d;
        while (!bus.addr_ok && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.addr_ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: addr_ok stayed 0 for addr %h", a);
            bus.req = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            bus.req = 1'b0;
            model_accept(w, strb, a, d);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (exp_due_q.size() != 0 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (exp_due_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d responses outstanding", exp_due_q.size());
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        exp_q.delete();
        exp_due_q.delete();
        last_rdata = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.req   = 1'b0;
        bus.wr    = 1'b0;
        bus.size  = SZ_WORD;
        bus.wstrb = 4'h0;
        bus.addr  = '0;
        bus.wdata = '0;

        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check1("reset_data_ok", bus.data_ok, 1'b0);
        check32("reset_rdata", bus.rdata, 32'h0);
        check1("reset_addr_ok", bus.addr_ok, 1'b1);
        mon_en = 1'b1;

        // Give every RAM word a known value.
        for (int i = 0; i < WORDS; i++) issue(1'b1, 4'hF, 32'(i * 4), $urandom);
        drain();

        // Single load.
        issue(1'b1, 4'hF, 32'h40, 32'h89ABCDEF);
        drain();
        issue(1'b0, 4'h0, 32'h40, 32'h0);
        drain();

        // Byte-strobe store then load on the following cycle.
        issue(1'b1, 4'hF, 32'h44, 32'h11223344);
        drain();
        issue(1'b1, 4'b0100, 32'h44, 32'h5A5A5A5A);
        issue(1'b0, 4'h0, 32'h44, 32'h0);
        drain();

        // Held request against a full queue.
        issue(1'b0, 4'h0, 32'h10, 32'h0);
        issue(1'b0, 4'h0, 32'h14, 32'h0);
        issue(1'b0, 4'h0, 32'h18, 32'h0);
        drain();

        // Streaming loads; the timestamp wraps several times.
        for (int i = 0; i < 16; i++) issue(1'b0, 4'h0, 32'(i * 4), 32'h0);
        drain();

        // Load older than a store to the same word, then a later load.
        issue(1'b1, 4'hF, 32'h80, 32'hDEADBEEF);
        drain();
        issue(1'b0, 4'h0, 32'h80, 32'h0);
        issue(1'b1, 4'hF, 32'h80, 32'h0);
        issue(1'b0, 4'h0, 32'h80, 32'h0);
        drain();

        // Zero-strobe store is answered without changing memory.
        issue(1'b1, 4'h0, 32'h80, 32'hFFFFFFFF);
        issue(1'b0, 4'h0, 32'h80, 32'h0);
        drain();

        // Random mix: full 32-bit addresses exercise aliasing.
        for (int i = 0; i < 300; i++) begin
            issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        drain();

        // Reset with two loads in flight; earlier store must survive.
        issue(1'b1, 4'hF, 32'h100, 32'hCAFEF00D);
        drain();
        issue(1'b0, 4'h0, 32'h104, 32'h0);
        issue(1'b0, 4'h0, 32'h108, 32'h0);
        pulse_reset();
        idle(6);
        issue(1'b0, 4'h0, 32'h100, 32'h0);
        drain();
        idle(3);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_sram_like_responder.md
Name: data_sram_like_responder

Overview:
- Slave end of the pipeline's data-memory port: accepts sram-like requests (req/addr_ok, then data_ok/rdata) from the CPU data side and services them from an internal word-addressed RAM.
- Is the source of the read data that the memory stage aligns and sign-extends.
- Supports multiple outstanding requests with a fixed response latency and strictly in-order responses.
- Serves both as the SoC-side data RAM model in simulation and as the reference responder for the pipeline's load/store path.

Parameters:
- AW, 12, word-address width; RAM holds 2^AW 32-bit words.
- LAT, 2, cycles from request acceptance to data_ok; legal range 1..7.
- QDEPTH, 2, maximum outstanding (accepted, not yet responded) requests; legal range 1..4.

Ports:
- clk  input  1  clock.
- resetn  input  1  reset, synchronous, active-low.
- req  input  1  request valid from CPU.
- wr  input  1  1 = store, 0 = load.
- size  input  2  0 = byte, 1 = half, 2 = word; informational only, wstrb governs writes.
- wstrb  input  4  byte-lane write enables; ignored when wr = 0.
- addr  input  32  byte address; bits [AW+1:2] index the RAM, all other bits ignored.
- wdata  input  32  store data, already lane-replicated by the requester.
- addr_ok  output  1  request accepted this cycle when req & addr_ok.
- data_ok  output  1  one-cycle response pulse for the oldest outstanding request.
- rdata  output  32  load data, valid with data_ok; 0 for store responses.

Behaviour:
- Reset (resetn = 0 at posedge): queue emptied, count = 0, timestamp counter cleared, data_ok = 0, rdata = 0. addr_ok is 1 from the first cycle after reset.
- RAM contents are not reset. A reset in the middle of operation discards every pending response; stores already accepted remain written.
- addr_ok = (count < QDEPTH). It depends only on registered count, not on req and not on the same-cycle retire.
- Acceptance cycle (req & addr_ok):
  - Stores: RAM word updated at this posedge, byte lane i written only if wstrb[i].
  - Loads: the RAM word is read at this posedge and the value stored in the queue entry. The load therefore returns the RAM state before any later-accepted store.
  - A store accepted in cycle N is visible to a load accepted in cycle N+1 or later.
- Each queue entry holds {is_load, data, due_time}. A free-running 3-bit timestamp counter is used; due_time = now + LAT mod 8, and wrap-around compare is equality only.
- data_ok is a register. It is 1 in the cycle exactly LAT cycles after acceptance, i.e. acceptance at edge N gives data_ok high during cycle N+LAT. It is high for one cycle per request.
- rdata is registered with data_ok; it holds the last value when data_ok = 0.
- There is no back-pressure on responses: the requester must take data_ok when it occurs.
- Responses are strictly in acceptance order. Fixed latency guarantees that the head is always the next entry due.
- Count update:
  - count +1 on accept.
  - count −1 on the retire edge, i.e. the edge that sets data_ok.
  - Both on the same edge: count unchanged.
- Full: with count = QDEPTH, req is held off (addr_ok = 0). The requester must keep req/addr/wdata stable until accepted.
- Throughput: QDEPTH ≥ LAT+1 sustains one request per cycle. With QDEPTH = 1, back-to-back requests are spaced LAT+1 cycles apart.
- addr bits [1:0] and misalignment are not checked; alignment exceptions are raised upstream. Addresses beyond 2^AW words alias by truncation.
- A store with wstrb = 4'b0000 is still accepted and responded, with no RAM change.

Decomposition:
- Shared package, cpu-wide header: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), data-bus width 32, strobe width 4.
- One sub-module: resp_queue. It is a QDEPTH-entry circular FIFO holding {is_load, data, due_time}, with head/tail pointers, count, push/pop, and full/empty flags.
- The top level holds the RAM array, the timestamp counter, the accept/retire logic and the output registers.

Test Plan:
- Single load, LAT = 2: RAM[0x10] preset to 0x89ABCDEF; load from addr 0x40 accepted at cycle 5 -> data_ok = 1 only in cycle 7 with rdata = 0x89ABCDEF.
- Byte-strobe store then load: store to addr 0x44 with wdata 0x5A5A5A5A, wstrb 4'b0100, old word 0x11223344; next cycle load 0x44 -> rdata 0x115A3344. The store's data_ok carries rdata = 0.
- Full back-pressure, QDEPTH = 2, LAT = 3: req held high with three loads -> first two accepted on consecutive cycles, addr_ok = 0 for the third until the first retires; the third is accepted that same cycle, and three data_ok pulses arrive in order.
- Streaming, QDEPTH = 4, LAT = 2: 16 back-to-back loads of addresses 0..60 step 4 -> accepted every cycle, 16 consecutive data_ok cycles, in-order data; the timestamp wraps with no missed or duplicated response.
- Load-before-store ordering: load 0x80 (old 0xDEADBEEF) accepted, store 0x80 = 0x0 accepted the next cycle -> the load response is 0xDEADBEEF, and a later load of 0x80 returns 0x0.
- Reset mid-flight: two loads outstanding, resetn = 0 for one cycle -> no data_ok ever for them, addr_ok = 1 after reset, and an earlier accepted store remains visible.
